nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/ltc_sched_pkg.sv | 14 +
 rtl/nonce_scheduler_rr_arbiter.sv | 45 ++++
 rtl/nonce_scheduler.sv | 177 +++++++++++++++++
 tb/tb_nonce_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc_sched_pkg.sv
// Shared widths and FSM encoding for the nonce scheduler.
package ltc_sched_pkg;

  localparam int NONCE_W   = 32;
  localparam int WORK_ID_W = 4;
  localparam int STALE_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_EXHAUSTED = 2'd2
  } sched_state_e;

endpackage

// File: rtl/nonce_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past the
// winner only when the caller says the grant was taken.
module rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  input  logic             advance,
  output logic [WIDTH-1:0] gnt
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PW-1:0] ptr_q, ptr_d, win_next;

  always_comb begin
    int   idx;
    logic found;
    gnt      = '0;
    win_next = ptr_q;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_next = (idx == WIDTH - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Kept apart from the search so advance (derived from gnt) forms no loop.
  always_comb begin
    ptr_d = advance ? win_next : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Hands out nonces to hasher cores and funnels their golden results to the
// serial transmitter. Define NONCE_SCHED_STALE_FILTER_EN to drop stale results.
module nonce_scheduler
  import ltc_sched_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           work_load,
  input  logic [NONCE_W-1:0]             work_nonce,
  input  logic [NUM_CORES-1:0]           core_req,
  output logic [NUM_CORES-1:0]           core_gnt,
  output logic [NONCE_W-1:0]             core_nonce,
  output logic [WORK_ID_W-1:0]           core_work_id,
  input  logic [NUM_CORES-1:0]           res_valid,
  input  logic [NUM_CORES*NONCE_W-1:0]   res_nonce,
  input  logic [NUM_CORES*WORK_ID_W-1:0] res_work_id,
  output logic [NUM_CORES-1:0]           res_ack,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NONCE_W-1:0]             out_nonce,
  output logic [1:0]                     state_o,
  output logic [STALE_W-1:0]             stale_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  sched_state_e         state_q, state_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [WORK_ID_W-1:0] work_id_q, work_id_d;
  logic [NONCE_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [NONCE_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic [NUM_CORES-1:0] grant_req, grant_vec, res_elig, ack_vec, res_stale;
  logic                 grant_any, push, pop, push_stale, fifo_full, fifo_empty;
  logic [NONCE_W-1:0]   push_nonce;

`ifdef NONCE_SCHED_STALE_FILTER_EN
  logic [STALE_W-1:0]   stale_q, stale_d;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      res_stale[i] = res_work_id[i*WORK_ID_W +: WORK_ID_W] != work_id_q;
    end
  end
`else
  logic unused_work_id;
  assign unused_work_id = ^res_work_id;
  assign res_stale      = '0;
`endif

  assign fifo_full  = count_q == CW'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;

  // Load wins over grant; stale results bypass the full check since they are never stored.
  assign grant_req = (state_q == ST_RUN && !work_load) ? core_req : '0;
  assign res_elig  = (state_q != ST_IDLE) ? (res_valid & (res_stale | {NUM_CORES{!fifo_full}})) : '0;
  assign grant_any = |grant_vec;

  rr_arbiter #(.WIDTH(NUM_CORES)) u_grant_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .req     (grant_req),
    .advance (grant_any),
    .gnt     (grant_vec)
  );

  rr_arbiter #(.WIDTH(NUM_CORES)) u_result_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .req     (res_elig),
    .advance (|ack_vec),
    .gnt     (ack_vec)
  );

  always_comb begin
    push_nonce = '0;
    push_stale = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (ack_vec[i]) begin
        push_nonce = res_nonce[i*NONCE_W +: NONCE_W];
        push_stale = res_stale[i];
      end
    end
  end

  assign push = (|ack_vec) && !push_stale;
  assign pop  = !fifo_empty && out_ready;

  always_comb begin
    state_d = state_q;
    if (work_load) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (grant_any && nonce_q == '1) state_d = ST_EXHAUSTED;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    nonce_d   = nonce_q;
    work_id_d = work_id_q;
    if (work_load) begin
      nonce_d   = work_nonce;
      work_id_d = work_id_q + WORK_ID_W'(1);
    end else if (grant_any) begin
      nonce_d   = nonce_q + NONCE_W'(1);
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_nonce;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

`ifdef NONCE_SCHED_STALE_FILTER_EN
  always_comb begin
    stale_d = stale_q;
    if (push_stale && stale_q != '1) stale_d = stale_q + STALE_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stale_q <= '0;
    else          stale_q <= stale_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      nonce_q   <= '0;
      work_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      nonce_q   <= nonce_d;
      work_id_q <= work_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fifo_q    <= fifo_d;
    end
  end

  always_comb begin
    core_gnt     = grant_vec;
    core_nonce   = nonce_q;
    core_work_id = work_id_q;
    res_ack      = ack_vec;
    out_valid    = !fifo_empty;
    out_nonce    = fifo_empty ? '0 : fifo_q[rd_ptr_q];
    state_o      = state_q;
`ifdef NONCE_SCHED_STALE_FILTER_EN
    stale_count  = stale_q;
`else
    stale_count  = '0;
`endif
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Scenario bench for nonce_scheduler: grant and result scoreboards per task.
module tb_nonce_scheduler;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          work_load = 1'b0;
  logic [31:0]   work_nonce = '0;
  logic [NC-1:0] core_req = '0;
  logic [NC-1:0] core_gnt;
  logic [31:0]   core_nonce;
  logic [3:0]    core_work_id;
  logic [NC-1:0] res_valid = '0;
  logic [NC*32-1:0] res_nonce = '0;
  logic [NC*4-1:0]  res_work_id = '0;
  logic [NC-1:0] res_ack;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_nonce;
  logic [1:0]    state_o;
  logic [15:0]   stale_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [31:0] nonce;
    logic [3:0]  id;
  } gnt_exp_t;

  gnt_exp_t    gnt_sb[$];
  logic [31:0] out_sb[$];

  nonce_scheduler #(.NUM_CORES(NC), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .work_load    (work_load),
    .work_nonce   (work_nonce),
    .core_req     (core_req),
    .core_gnt     (core_gnt),
    .core_nonce   (core_nonce),
    .core_work_id (core_work_id),
    .res_valid    (res_valid),
    .res_nonce    (res_nonce),
    .res_work_id  (res_work_id),
    .res_ack      (res_ack),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_nonce    (out_nonce),
    .state_o      (state_o),
    .stale_count  (stale_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    core_req = '1;
    #2;
    checks++;
    if ({state_o, core_gnt, res_ack, out_valid, out_nonce, core_nonce, core_work_id, stale_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got state=%0d gnt=%b ack=%b ov=%b on=%h cn=%h id=%h sc=%0d exp all 0",
               state_o, core_gnt, res_ack, out_valid, out_nonce, core_nonce, core_work_id, stale_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (core_gnt !== '0 || state_o !== 2'd0) begin
        errors++;
        $display("[TB] FAIL idle_no_grant got gnt=%b state=%0d exp gnt=0000 state=0", core_gnt, state_o);
      end
      @(negedge clk);
    end
    core_req = '0;
  endtask

  task automatic test_grant_rr();
    gnt_exp_t e;
    @(negedge clk);
    work_load = 1'b1; work_nonce = 32'h0000_318E; core_req = 4'hF;
    gnt_sb.push_back({4'b0001, 32'h0000_318E, 4'd1});
    gnt_sb.push_back({4'b0010, 32'h0000_318F, 4'd1});
    gnt_sb.push_back({4'b0100, 32'h0000_3190, 4'd1});
    gnt_sb.push_back({4'b1000, 32'h0000_3191, 4'd1});
    gnt_sb.push_back({4'b0001, 32'h0000_3192, 4'd1});
    @(negedge clk);
    work_load = 1'b0;
    for (int c = 0; c < 20 && gnt_sb.size() > 0; c++) begin
      #2;
      if (core_gnt !== '0) begin
        e = gnt_sb.pop_front();
        checks++;
        if ({core_gnt, core_nonce, core_work_id} !== e) begin
          errors++;
          $display("[TB] FAIL rr_grant got gnt=%b nonce=%h id=%0d exp gnt=%b nonce=%h id=%0d",
                   core_gnt, core_nonce, core_work_id, e.gnt, e.nonce, e.id);
        end
      end
      @(negedge clk);
    end
    core_req = '0;
    checks++;
    if (gnt_sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_grant_timeout got %0d pending exp 0", gnt_sb.size());
      gnt_sb.delete();
    end
  endtask

  task automatic test_exhaust();
    gnt_exp_t e;
    @(negedge clk);
    work_load = 1'b1; work_nonce = 32'hFFFF_FFFE; core_req = 4'b0100;
    gnt_sb.push_back({4'b0100, 32'hFFFF_FFFE, 4'd2});
    gnt_sb.push_back({4'b0100, 32'hFFFF_FFFF, 4'd2});
    @(negedge clk);
    work_load = 1'b0;
    for (int c = 0; c < 10 && gnt_sb.size() > 0; c++) begin
      #2;
      if (core_gnt !== '0) begin
        e = gnt_sb.pop_front();
        checks++;
        if ({core_gnt, core_nonce, core_work_id} !== e) begin
          errors++;
          $display("[TB] FAIL exhaust_grant got gnt=%b nonce=%h id=%0d exp gnt=%b nonce=%h id=%0d",
                   core_gnt, core_nonce, core_work_id, e.gnt, e.nonce, e.id);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (gnt_sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL exhaust_timeout got %0d pending exp 0", gnt_sb.size());
      gnt_sb.delete();
    end
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (state_o !== 2'd2 || core_gnt !== '0) begin
        errors++;
        $display("[TB] FAIL exhausted_hold got state=%0d gnt=%b exp state=2 gnt=0000", state_o, core_gnt);
      end
      @(negedge clk);
    end
    core_req = '0;
  endtask

  task automatic test_stale();
    logic [31:0] exp_n;
    @(negedge clk);
    res_nonce[63:32] = 32'hDEAD_0001; res_work_id[7:4] = 4'd1; res_valid = 4'b0010;
`ifndef NONCE_SCHED_STALE_FILTER_EN
    out_sb.push_back(32'hDEAD_0001);
`endif
    #2;
    checks++;
    if (res_ack !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL stale_ack got %b exp 0010", res_ack);
    end
    @(negedge clk);
    res_valid = '0;
    #2;
`ifdef NONCE_SCHED_STALE_FILTER_EN
    checks++;
    if (out_valid !== 1'b0 || stale_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL stale_drop got ov=%b sc=%0d exp ov=0 sc=1", out_valid, stale_count);
    end
`else
    exp_n = out_sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_nonce !== exp_n || stale_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stale_pass got ov=%b on=%h sc=%0d exp ov=1 on=%h sc=0", out_valid, out_nonce, stale_count, exp_n);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stale_pass_pop got ov=%b exp 0", out_valid);
    end
`endif
  endtask

  task automatic test_fifo_full();
    logic [3:0]  exp_ack [4];
    logic [3:0]  seen;
    logic [31:0] exp_n;
    logic        reloaded;
    exp_ack = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
    reloaded = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    res_work_id = {4{4'd2}};
    res_nonce = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    res_valid = 4'hF;
    out_sb.push_back(32'hA000_0002); out_sb.push_back(32'hA000_0003);
    out_sb.push_back(32'hA000_0000); out_sb.push_back(32'hA000_0001);
    out_sb.push_back(32'hA000_0004);
    for (int k = 0; k < 4; k++) begin
      #2;
      seen = res_ack;
      checks++;
      if (res_ack !== exp_ack[k]) begin
        errors++;
        $display("[TB] FAIL fill_ack%0d got %b exp %b", k, res_ack, exp_ack[k]);
      end
      @(negedge clk);
      res_valid = res_valid & ~seen;
      if (seen[0] && !reloaded) begin
        res_valid[0] = 1'b1; res_nonce[31:0] = 32'hA000_0004; reloaded = 1'b1;
      end
    end
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (res_ack !== 4'b0000 || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL full_withhold got ack=%b ov=%b exp ack=0000 ov=1", res_ack, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2;
    exp_n = out_sb.pop_front();
    checks++;
    if (res_ack !== 4'b0000 || out_nonce !== exp_n) begin
      errors++;
      $display("[TB] FAIL full_pop got ack=%b on=%h exp ack=0000 on=%h", res_ack, out_nonce, exp_n);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    checks++;
    if (res_ack !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL fifth_ack got %b exp 0001", res_ack);
    end
    @(negedge clk);
    res_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && out_sb.size() > 0; c++) begin
      #2;
      if (out_valid === 1'b1) begin
        exp_n = out_sb.pop_front();
        checks++;
        if (out_nonce !== exp_n) begin
          errors++;
          $display("[TB] FAIL drain got %h exp %h", out_nonce, exp_n);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got %0d pending exp 0", out_sb.size());
      out_sb.delete();
    end
  endtask

  task automatic test_load_vs_grant();
    @(negedge clk);
    work_load = 1'b1; work_nonce = 32'h0000_0100;
    @(negedge clk);
    work_nonce = 32'h1234_0000; core_req = 4'b0010;
    #2;
    checks++;
    if (core_gnt !== 4'b0000 || state_o !== 2'd1) begin
      errors++;
      $display("[TB] FAIL load_blocks_grant got gnt=%b state=%0d exp gnt=0000 state=1", core_gnt, state_o);
    end
    @(negedge clk);
    work_load = 1'b0;
    gnt_sb.push_back({4'b0010, 32'h1234_0000, 4'd4});
    #2;
    if (core_gnt !== '0) begin
      gnt_exp_t e;
      e = gnt_sb.pop_front();
      checks++;
      if ({core_gnt, core_nonce, core_work_id} !== e) begin
        errors++;
        $display("[TB] FAIL post_load_grant got gnt=%b nonce=%h id=%0d exp gnt=%b nonce=%h id=%0d",
                 core_gnt, core_nonce, core_work_id, e.gnt, e.nonce, e.id);
      end
    end
    checks++;
    if (gnt_sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_load_missing got no grant exp gnt=0010");
      gnt_sb.delete();
    end
    @(negedge clk);
    core_req = '0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    int acks;
    acks = 0;
    @(negedge clk);
    res_work_id = {4{4'd4}};
    res_nonce[31:0] = 32'hB000_0000; res_nonce[63:32] = 32'hB000_0001;
    res_valid = 4'b0011;
    out_sb.push_back(32'hB000_0001); out_sb.push_back(32'hB000_0000);
    for (int c = 0; c < 6 && acks < 2; c++) begin
      #2;
      seen = res_ack;
      if (seen !== '0) acks++;
      @(negedge clk);
      res_valid = res_valid & ~seen;
    end
    #2;
    checks++;
    if (acks != 2 || out_valid !== 1'b1 || out_nonce !== out_sb[0]) begin
      errors++;
      $display("[TB] FAIL mid_fill got acks=%0d ov=%b on=%h exp acks=2 ov=1 on=%h", acks, out_valid, out_nonce, out_sb[0]);
    end
    @(negedge clk);
    reset_n = 1'b0; core_req = '1; res_valid = '1;
    #1;
    checks++;
    if ({state_o, core_gnt, res_ack, out_valid, core_nonce, core_work_id, stale_count} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got state=%0d gnt=%b ack=%b ov=%b cn=%h id=%h sc=%0d exp all 0",
               state_o, core_gnt, res_ack, out_valid, core_nonce, core_work_id, stale_count);
    end
    out_sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (core_gnt !== '0 || res_ack !== '0 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_quiet got gnt=%b ack=%b ov=%b exp 0", core_gnt, res_ack, out_valid);
      end
      @(negedge clk);
    end
    res_valid = '0; core_req = 4'b0001;
    work_load = 1'b1; work_nonce = 32'h0000_0055;
    @(negedge clk);
    work_load = 1'b0;
    #2;
    checks++;
    if (core_gnt !== 4'b0001 || core_nonce !== 32'h0000_0055 || core_work_id !== 4'd1) begin
      errors++;
      $display("[TB] FAIL reload_grant got gnt=%b nonce=%h id=%0d exp gnt=0001 nonce=00000055 id=1",
               core_gnt, core_nonce, core_work_id);
    end
    @(negedge clk);
    core_req = '0;
  endtask

  initial begin
    test_reset();
    test_grant_rr();
    test_exhaust();
    test_stale();
    test_fifo_full();
    test_load_vs_grant();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
